// File: rtl/arith_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : arith_sequencer
// Description : Four-phase instruction sequencer (IDLE/DECODE/EXEC/WB) for a
//               MIPS-style ALU datapath. Latches one instruction at a time,
//               hands opcode/funct to an external decoder, registers the
//               decoder's controls, and strobes the register-file write.
//               Exceptions are counted and can halt the sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
module arith_sequencer (
    input  logic        clk,
    input  logic        reset,
    input  logic        inst_valid,
    input  logic [31:0] inst,
    output logic        inst_ready,
    input  logic        stop_on_except,
    output logic [5:0]  opcode,
    output logic [5:0]  funct,
    input  logic        dec_rd_src,
    input  logic        dec_writeenable,
    input  logic        dec_except,
    input  logic [1:0]  dec_alu_src2,
    input  logic [2:0]  dec_alu_op,
    output logic [4:0]  rs_addr,
    output logic [4:0]  rt_addr,
    output logic [4:0]  rd_addr,
    output logic [15:0] imm,
    output logic [2:0]  alu_op,
    output logic [1:0]  alu_src2,
    output logic        rf_wr_en,
    output logic        exc_valid,
    output logic [7:0]  exc_count,
    output logic [15:0] retired,
    output logic [2:0]  state
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        WB     = 3'd3,
        EXCEPT = 3'd4,
        HALT   = 3'd5
    } state_t;

    localparam logic [4:0] c_ZERO_REG  = 5'd0;
    localparam logic [7:0] c_EXC_MAX   = 8'hFF;

    state_t      state_q, state_d;
    logic [31:0] inst_q;
    logic [4:0]  rs_q, rt_q, rd_q;
    logic [15:0] imm_q;
    logic [2:0]  alu_op_q;
    logic [1:0]  alu_src2_q;
    logic        we_q;
    logic        rf_wr_en_q;
    logic        exc_valid_q;
    logic [7:0]  exc_count_q;
    logic [15:0] retired_q;

    // Acceptance is only possible while idle; inst_ready has no other source.
    logic accept;
    assign inst_ready = (state_q == IDLE);
    assign accept     = inst_ready && inst_valid;

    // State register; reset abandons any in-flight instruction, even from HALT.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: fixed 4-cycle pipeline, exceptions detour via EXCEPT.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = DECODE;
            DECODE:  state_d = dec_except ? EXCEPT : EXEC;
            EXEC:    state_d = WB;
            WB:      state_d = IDLE;
            EXCEPT:  state_d = stop_on_except ? HALT : IDLE;
            HALT:    state_d = HALT;
            default: state_d = IDLE;
        endcase
    end

    // Datapath registers: instruction latch, decoded fields, strobes, counters.
    always_ff @(posedge clk) begin
        if (!reset) begin
            inst_q      <= '0;
            rs_q        <= '0;
            rt_q        <= '0;
            rd_q        <= '0;
            imm_q       <= '0;
            alu_op_q    <= '0;
            alu_src2_q  <= '0;
            we_q        <= 1'b0;
            rf_wr_en_q  <= 1'b0;
            exc_valid_q <= 1'b0;
            exc_count_q <= '0;
            retired_q   <= '0;
        end else begin
            // Strobes are set on entry to WB / EXCEPT so they last exactly one cycle.
            rf_wr_en_q  <= (state_q == EXEC) && we_q && (rd_q != c_ZERO_REG);
            exc_valid_q <= (state_q == DECODE) && dec_except;

            if (accept) begin
                inst_q <= inst;
            end

            // Decoder answers are captured at the end of DECODE for use in EXEC/WB.
            if (state_q == DECODE) begin
                rs_q       <= inst_q[25:21];
                rt_q       <= inst_q[20:16];
                imm_q      <= inst_q[15:0];
                rd_q       <= dec_rd_src ? inst_q[20:16] : inst_q[15:11];
                alu_op_q   <= dec_alu_op;
                alu_src2_q <= dec_alu_src2;
                we_q       <= dec_writeenable;
                if (dec_except && (exc_count_q != c_EXC_MAX)) begin
                    exc_count_q <= exc_count_q + 8'd1;
                end
            end

            if (state_q == WB) begin
                retired_q <= retired_q + 16'd1;
            end
        end
    end

    assign opcode    = inst_q[31:26];
    assign funct     = inst_q[5:0];
    assign rs_addr   = rs_q;
    assign rt_addr   = rt_q;
    assign rd_addr   = rd_q;
    assign imm       = imm_q;
    assign alu_op    = alu_op_q;
    assign alu_src2  = alu_src2_q;
    assign rf_wr_en  = rf_wr_en_q;
    assign exc_valid = exc_valid_q;
    assign exc_count = exc_count_q;
    assign retired   = retired_q;
    assign state     = state_q;

endmodule
`default_nettype wire

// File: tb/tb_arith_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_arith_sequencer
// Description : Self-checking bench for arith_sequencer with a scoreboard of
//               expected decode/writeback results.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_arith_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        inst_valid;
    logic [31:0] inst;
    logic        inst_ready;
    logic        stop_on_except;
    logic [5:0]  opcode, funct;
    logic        dec_rd_src, dec_writeenable, dec_except;
    logic [1:0]  dec_alu_src2;
    logic [2:0]  dec_alu_op;
    logic [4:0]  rs_addr, rt_addr, rd_addr;
    logic [15:0] imm;
    logic [2:0]  alu_op;
    logic [1:0]  alu_src2;
    logic        rf_wr_en, exc_valid;
    logic [7:0]  exc_count;
    logic [15:0] retired;
    logic [2:0]  state;

    typedef struct {
        logic [5:0]  op;
        logic [5:0]  fn;
        logic [2:0]  alu_op;
        logic [1:0]  src2;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [15:0] imm;
        logic        wr;
    } exp_t;

    exp_t sb[$];
    int   pass_cnt = 0;
    int   total    = 0;
    int   exp_retired = 0;
    int   exp_exc     = 0;

    arith_sequencer dut (
        .clk            (clk),
        .reset          (reset),
        .inst_valid     (inst_valid),
        .inst           (inst),
        .inst_ready     (inst_ready),
        .stop_on_except (stop_on_except),
        .opcode         (opcode),
        .funct          (funct),
        .dec_rd_src     (dec_rd_src),
        .dec_writeenable(dec_writeenable),
        .dec_except     (dec_except),
        .dec_alu_src2   (dec_alu_src2),
        .dec_alu_op     (dec_alu_op),
        .rs_addr        (rs_addr),
        .rt_addr        (rt_addr),
        .rd_addr        (rd_addr),
        .imm            (imm),
        .alu_op         (alu_op),
        .alu_src2       (alu_src2),
        .rf_wr_en       (rf_wr_en),
        .exc_valid      (exc_valid),
        .exc_count      (exc_count),
        .retired        (retired),
        .state          (state)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drive one instruction plus the decoder's answer, and queue the expected result.
    task automatic issue(input logic [31:0] w, input logic [2:0] op, input logic [1:0] s2,
                         input logic rdsrc, input logic we, input logic exc, input logic stop);
        exp_t e;
        e.op     = w[31:26];
        e.fn     = w[5:0];
        e.alu_op = op;
        e.src2   = s2;
        e.rs     = w[25:21];
        e.rt     = w[20:16];
        e.rd     = rdsrc ? w[20:16] : w[15:11];
        e.imm    = w[15:0];
        e.wr     = we && !exc && (e.rd != 5'd0);
        sb.push_back(e);
        inst            = w;
        inst_valid      = 1'b1;
        dec_alu_op      = op;
        dec_alu_src2    = s2;
        dec_rd_src      = rdsrc;
        dec_writeenable = we;
        dec_except      = exc;
        stop_on_except  = stop;
    endtask

    task automatic apply_reset();
        reset = 1'b0;
        inst_valid = 1'b0;
        step();
        reset = 1'b1;
        exp_retired = 0;
        exp_exc     = 0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        inst_valid = 1'b0;
        step();
        total++; if (state !== 3'd0) $display("FAIL reset_state got=%0d exp=0", state); else pass_cnt++;
        total++; if (inst_ready !== 1'b1) $display("FAIL reset_ready got=%b exp=1", inst_ready); else pass_cnt++;
        total++;
        if ({opcode, funct, rs_addr, rt_addr, rd_addr, imm, alu_op, alu_src2, rf_wr_en, exc_valid} !== '0)
            $display("FAIL reset_outputs got=%h exp=0",
                     {opcode, funct, rs_addr, rt_addr, rd_addr, imm, alu_op, alu_src2, rf_wr_en, exc_valid});
        else pass_cnt++;
        total++; if ({exc_count, retired} !== 24'd0) $display("FAIL reset_counters got=%h exp=0", {exc_count, retired}); else pass_cnt++;
        reset = 1'b1;
        step();
    endtask

    task automatic test_add();
        exp_t e;
        issue(32'h00221820, 3'b010, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0);
        total++; if (inst_ready !== 1'b1) $display("FAIL add_ready got=%b exp=1", inst_ready); else pass_cnt++;
        step();
        inst_valid = 1'b0;
        e = sb.pop_front();
        total++; if (state !== 3'd1) $display("FAIL add_decode_state got=%0d exp=1", state); else pass_cnt++;
        total++; if ({opcode, funct} !== {e.op, e.fn}) $display("FAIL add_opfn got=%h exp=%h", {opcode, funct}, {e.op, e.fn}); else pass_cnt++;
        step();
        total++; if (state !== 3'd2) $display("FAIL add_exec_state got=%0d exp=2", state); else pass_cnt++;
        total++; if (alu_op !== e.alu_op) $display("FAIL add_alu_op got=%b exp=%b", alu_op, e.alu_op); else pass_cnt++;
        total++; if ({rs_addr, rt_addr} !== {e.rs, e.rt}) $display("FAIL add_rs_rt got=%h exp=%h", {rs_addr, rt_addr}, {e.rs, e.rt}); else pass_cnt++;
        total++; if (rf_wr_en !== 1'b0) $display("FAIL add_exec_wr got=%b exp=0", rf_wr_en); else pass_cnt++;
        step();
        total++; if (state !== 3'd3) $display("FAIL add_wb_state got=%0d exp=3", state); else pass_cnt++;
        total++; if (rf_wr_en !== e.wr) $display("FAIL add_wb_wr got=%b exp=%b", rf_wr_en, e.wr); else pass_cnt++;
        total++; if (rd_addr !== e.rd) $display("FAIL add_rd got=%0d exp=%0d", rd_addr, e.rd); else pass_cnt++;
        step();
        exp_retired++;
        total++; if (retired !== 16'(exp_retired)) $display("FAIL add_retired got=%0d exp=%0d", retired, exp_retired); else pass_cnt++;
        total++; if ({state, rf_wr_en} !== 4'b0000) $display("FAIL add_idle got=%b exp=0000", {state, rf_wr_en}); else pass_cnt++;
    endtask

    task automatic test_addi();
        exp_t e;
        issue(32'h2005FFFF, 3'b010, 2'b01, 1'b1, 1'b1, 1'b0, 1'b0);
        step();
        inst_valid = 1'b0;
        e = sb.pop_front();
        step();
        total++; if (imm !== e.imm) $display("FAIL addi_imm got=%h exp=%h", imm, e.imm); else pass_cnt++;
        total++; if (alu_src2 !== e.src2) $display("FAIL addi_src2 got=%b exp=%b", alu_src2, e.src2); else pass_cnt++;
        step();
        total++; if ({rd_addr, rf_wr_en} !== {e.rd, e.wr}) $display("FAIL addi_wb got=%h exp=%h", {rd_addr, rf_wr_en}, {e.rd, e.wr}); else pass_cnt++;
        step();
        exp_retired++;
        total++; if (retired !== 16'(exp_retired)) $display("FAIL addi_retired got=%0d exp=%0d", retired, exp_retired); else pass_cnt++;
    endtask

    task automatic test_reg_zero();
        exp_t e;
        issue(32'h00220020, 3'b010, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0);
        for (int c = 1; c <= 4; c++) begin
            step();
            inst_valid = 1'b0;
            if (c == 1) e = sb.pop_front();
            total++; if (rf_wr_en !== e.wr) $display("FAIL r0_wr cyc=%0d got=%b exp=%b", c, rf_wr_en, e.wr); else pass_cnt++;
        end
        exp_retired++;
        total++; if (retired !== 16'(exp_retired)) $display("FAIL r0_retired got=%0d exp=%0d", retired, exp_retired); else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        exp_t e;
        logic [31:0] words [3];
        words[0] = 32'h00853020;  // add $6,$4,$5
        words[1] = 32'h00E84822;  // sub $9,$7,$8
        words[2] = 32'h014B6025;  // or  $12,$10,$11
        for (int k = 0; k < 3; k++) begin
            total++; if (inst_ready !== 1'b1) $display("FAIL b2b_ready_idle k=%0d got=%b exp=1", k, inst_ready); else pass_cnt++;
            issue(words[k], 3'(k + 1), 2'b00, 1'b0, 1'b1, 1'b0, 1'b0);
            e = sb.pop_front();
            for (int c = 1; c <= 3; c++) begin
                step();
                // Offer a different word while busy; it must be ignored.
                inst = 32'hFFFF_FFFF;
                total++; if (inst_ready !== 1'b0) $display("FAIL b2b_ready_busy k=%0d c=%0d got=%b exp=0", k, c, inst_ready); else pass_cnt++;
                if (c == 2) begin
                    total++; if ({opcode, funct, alu_op} !== {e.op, e.fn, e.alu_op}) $display("FAIL b2b_latch k=%0d got=%h exp=%h", k, {opcode, funct, alu_op}, {e.op, e.fn, e.alu_op}); else pass_cnt++;
                end
                if (c == 3) begin
                    total++; if ({rd_addr, rf_wr_en} !== {e.rd, e.wr}) $display("FAIL b2b_wb k=%0d got=%h exp=%h", k, {rd_addr, rf_wr_en}, {e.rd, e.wr}); else pass_cnt++;
                end
            end
            step();
            exp_retired++;
        end
        inst_valid = 1'b0;
        total++; if (retired !== 16'(exp_retired)) $display("FAIL b2b_retired got=%0d exp=%0d", retired, exp_retired); else pass_cnt++;
    endtask

    task automatic test_saturate();
        exp_t e;
        apply_reset();
        step();
        for (int n = 0; n < 300; n++) begin
            issue(32'h8C220000, 3'b000, 2'b00, 1'b1, 1'b1, 1'b1, 1'b0);
            step();
            inst_valid = 1'b0;
            e = sb.pop_front();
            step();
            if (exp_exc < 255) exp_exc++;
            total++; if ({exc_valid, rf_wr_en} !== {1'b1, e.wr}) $display("FAIL sat_pulse n=%0d got=%b exp=%b", n, {exc_valid, rf_wr_en}, {1'b1, e.wr}); else pass_cnt++;
            step();
        end
        total++; if (exc_count !== 8'(exp_exc)) $display("FAIL sat_count got=%0d exp=%0d", exc_count, exp_exc); else pass_cnt++;
        total++; if (retired !== 16'(exp_retired)) $display("FAIL sat_retired got=%0d exp=%0d", retired, exp_retired); else pass_cnt++;
        total++; if (exc_valid !== 1'b0) $display("FAIL sat_pulse_end got=%b exp=0", exc_valid); else pass_cnt++;
    endtask

    task automatic test_except_halt();
        exp_t e;
        apply_reset();
        step();
        issue(32'h8C220000, 3'b000, 2'b00, 1'b1, 1'b1, 1'b1, 1'b1);
        step();
        e = sb.pop_front();
        step();
        exp_exc++;
        total++; if ({state, exc_valid, rf_wr_en} !== {3'd4, 1'b1, e.wr}) $display("FAIL halt_except got=%b exp=%b", {state, exc_valid, rf_wr_en}, {3'd4, 1'b1, e.wr}); else pass_cnt++;
        total++; if (exc_count !== 8'(exp_exc)) $display("FAIL halt_count got=%0d exp=%0d", exc_count, exp_exc); else pass_cnt++;
        for (int c = 0; c < 5; c++) begin
            step();
            total++; if ({state, inst_ready, exc_valid, rf_wr_en} !== {3'd5, 3'b000}) $display("FAIL halt_hold c=%0d got=%b exp=101000", c, {state, inst_ready, exc_valid, rf_wr_en}); else pass_cnt++;
        end
        total++; if (retired !== 16'(exp_retired)) $display("FAIL halt_retired got=%0d exp=%0d", retired, exp_retired); else pass_cnt++;
        inst_valid = 1'b0;
    endtask

    task automatic test_reset_mid();
        apply_reset();
        total++; if ({state, inst_ready} !== 4'b0001) $display("FAIL rst_from_halt got=%b exp=0001", {state, inst_ready}); else pass_cnt++;
        step();
        issue(32'h00221820, 3'b010, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0);
        step();
        inst_valid = 1'b0;
        step();
        total++; if (state !== 3'd2) $display("FAIL rstmid_exec got=%0d exp=2", state); else pass_cnt++;
        reset = 1'b0;
        step();
        void'(sb.pop_front());
        total++; if ({state, rf_wr_en, inst_ready} !== 5'b00001) $display("FAIL rstmid_state got=%b exp=00001", {state, rf_wr_en, inst_ready}); else pass_cnt++;
        total++; if ({exc_count, retired} !== 24'd0) $display("FAIL rstmid_counters got=%h exp=0", {exc_count, retired}); else pass_cnt++;
        reset = 1'b1;
        step();
        total++; if ({rf_wr_en, retired} !== 17'd0) $display("FAIL rstmid_after got=%h exp=0", {rf_wr_en, retired}); else pass_cnt++;
    endtask

    initial begin
        reset = 1'b0;
        inst_valid = 1'b0;
        inst = '0;
        stop_on_except = 1'b0;
        dec_rd_src = 1'b0;
        dec_writeenable = 1'b0;
        dec_except = 1'b0;
        dec_alu_src2 = '0;
        dec_alu_op = '0;
        test_reset();
        test_add();
        test_addi();
        test_reg_zero();
        test_back_to_back();
        test_saturate();
        test_except_halt();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire

// File: doc/arith_sequencer.md
ARITH_SEQUENCER -- requirements
Module: arith_sequencer

Interface
REQ-001 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-002 SHALL have port reset, input, 1, reset that is synchronous and active-low (0 = reset, sampled on the clk rising edge).
REQ-003 SHALL have port inst_valid, input, 1, the instruction offered this cycle.
REQ-004 SHALL have port inst, input, 32, MIPS instruction word.
REQ-005 SHALL have port inst_ready, output, 1, sequencer accepts inst this cycle.
REQ-006 SHALL have port stop_on_except, input, 1, 1 = enter HALT after an exception.
REQ-007 SHALL have port opcode, output, 6, latched inst[31:26], driving the decoder.
REQ-008 SHALL have port funct, output, 6, latched inst[5:0], driving the decoder.
REQ-009 SHALL have decoder-return inputs: dec_rd_src 1, dec_writeenable 1, dec_except 1, dec_alu_src2 2, dec_alu_op 3.
REQ-010 SHALL have port rs_addr, output, 5, latched inst[25:21].
REQ-011 SHALL have port rt_addr, output, 5, latched inst[20:16].
REQ-012 SHALL have port rd_addr, output, 5, write destination: inst[15:11] if dec_rd_src=0, else inst[20:16].
REQ-013 SHALL have port imm, output, 16, latched inst[15:0].
REQ-014 SHALL have port alu_op, output, 3, registered ALU control.
REQ-015 SHALL have port alu_src2, output, 2, registered ALU source-2 select.
REQ-016 SHALL have port rf_wr_en, output, 1, register-file write strobe.
REQ-017 SHALL have port exc_valid, output, 1, one-cycle exception pulse.
REQ-018 SHALL have port exc_count, output, 8, saturating exception counter.
REQ-019 SHALL have port retired, output, 16, wrapping retired-instruction counter.
REQ-020 SHALL have port state, output, 3, FSM state: IDLE=0, DECODE=1, EXEC=2, WB=3, EXCEPT=4, HALT=5.

Function
REQ-021 SHALL assert inst_ready combinationally iff state=IDLE; there is no other path to it.
REQ-022 SHALL accept an instruction only on a cycle T where inst_valid=1 and inst_ready=1: it latches inst and moves to DECODE at T+1.
REQ-023 In DECODE (T+1), SHALL present opcode/funct from the latched inst, sample all dec_* inputs at the end of the cycle, and go to EXCEPT if dec_except=1, else EXEC.
REQ-024 In EXEC (T+2), SHALL drive alu_op, alu_src2, rs_addr, rt_addr, imm and rd_addr from the sampled values, then go to WB.
REQ-025 In WB (T+3), SHALL assert rf_wr_en=1 for exactly one cycle iff dec_writeenable=1 and rd_addr!=0, SHALL increment retired by 1 (wrapping 0xFFFF->0), then go to IDLE at T+4.
REQ-026 Writes to register 0 SHALL be suppressed (rf_wr_en=0), but the instruction still retires.
REQ-027 Throughput SHALL be one instruction per 4 cycles; back-to-back inst_valid is accepted at T, T+4, T+8, and so on.
REQ-028 In EXCEPT (T+2), SHALL pulse exc_valid=1 for one cycle, keep rf_wr_en=0, increment exc_count saturating at 255, and leave retired unchanged.
REQ-029 From EXCEPT, SHALL go to HALT if stop_on_except=1 in that cycle, else to IDLE.
REQ-030 HALT SHALL be terminal until reset: inst_ready=0, rf_wr_en=0, exc_valid=0.
REQ-031 SHALL ignore inst and inst_valid in every state other than IDLE; the latched values SHALL NOT change.
REQ-032 In all states except WB, rf_wr_en SHALL be 0; in all states except EXCEPT, exc_valid SHALL be 0.

Reset
REQ-033 With reset=0 at a rising edge, the next cycle SHALL have state=IDLE, and all registered outputs (opcode, funct, rs/rt/rd_addr, imm, alu_op, alu_src2, rf_wr_en, exc_valid, exc_count, retired) SHALL be 0.
REQ-034 Reset SHALL override any state, including mid-instruction and HALT; an in-flight instruction is discarded with no write and no count update.

Verification
REQ-035 add $3,$1,$2 (0x00221820), decoder returns alu_op=010, rd_src=0, src2=00, we=1 -> at T+2 alu_op=010, rs=1, rt=2; at T+3 rf_wr_en=1 with rd_addr=3; retired=1 at T+4.
REQ-036 addi $5,$0,-1 (0x2005FFFF), rd_src=1, src2=01 -> imm=0xFFFF, alu_src2=01, rd_addr=5, rf_wr_en=1 at T+3.
REQ-037 add $0,$1,$2 (0x00220020) -> rf_wr_en stays 0 throughout, and retired still increments.
REQ-038 lw word 0x8C220000, dec_except=1, stop_on_except=1 -> exc_valid=1 at T+2, exc_count=1, state=HALT from T+3, and inst_ready=0 while inst_valid is held at 1.
REQ-039 300 consecutive excepting instructions with stop_on_except=0 -> exc_count=255 and retired=0.
REQ-040 Reset=0 asserted in EXEC of a valid add -> no rf_wr_en pulse; the next cycle has state=0, counters=0, inst_ready=1.
